cnn_layer_accel_job_dispatcher: RTL
===================================

// Module: cnn_layer_accel_job_dispatcher
// PURPOSE
//   Initiator side of the quad job protocol: accepts layer jobs from the host/sequencer and drives
//   job_start/job_parameters into every quad. Arbitrates quad fetch requests onto the single
//   memory-fetch port and acknowledges job completion.
//   Sits beside the quad array in the AWP; one instance serves all NUM_QUADS quads in lockstep.
// PARAMETERS
//   NUM_QUADS      4      number of quads driven (1..16)
//   JOB_W          128    job parameter word width
//   TIMEOUT_CYC    2**20  watchdog limit in clk_core cycles (used only with JOB_TIMEOUT_EN)
// PORTS
//   clk_core            in   1            core clock; all logic on rising edge
//   rst                 in   1            asynchronous assert, active-low reset
//   host_job_valid      in   1            host job offered
//   host_job_ready      out  1            dispatcher can take a job (IDLE)
//   host_job_data       in   JOB_W        job parameters
//   host_job_done       out  1            1-cycle pulse: job fully completed and acked
//   busy                out  1            state != IDLE
//   job_start           out  NUM_QUADS    per-quad start request
//   job_accept          in   NUM_QUADS    per-quad start accept
//   job_parameters      out  JOB_W        registered copy of host_job_data, broadcast
//   job_fetch_request   in   NUM_QUADS    per-quad fetch request (level)
//   job_fetch_ack       out  NUM_QUADS    one-hot 1-cycle grant pulse
//   job_fetch_complete  in   NUM_QUADS    granted quad's fetch finished (pulse)
//   job_complete        in   NUM_QUADS    per-quad job done (pulse or level)
//   job_complete_ack    out  NUM_QUADS    completion acknowledge
//   fetch_grant_id      out  clog2(NUM_QUADS)  index of quad currently owning fetch port
//   fetch_busy          out  1            a fetch is outstanding
//   timeout_err         out  1            sticky watchdog error (0 when JOB_TIMEOUT_EN undefined)
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 except host_job_ready=1; job_parameters=0; arbiter pointer=0.
//   FSM: IDLE -> START -> RUN -> CPL_ACK -> IDLE.
//   IDLE: host_job_ready=1; on host_job_valid&ready latch data into job_parameters, go START next cycle.
//   START: job_start[i]=1 for every quad whose accept is not yet seen. A quad's accept is recorded
//     in a sticky bit on job_start[i]&job_accept[i]. job_start[i] drops the following cycle.
//     When all accept bits are set, go RUN. job_parameters is stable from latch until IDLE.
//   RUN, fetch arbiter: round-robin over job_fetch_request, starting at (last grant+1) mod NUM_QUADS.
//     - When no fetch is outstanding, a grant pulses job_fetch_ack[i] for exactly 1 cycle.
//     - fetch_busy is then set until job_fetch_complete[i] of the granted quad.
//     - Completes from non-granted quads are ignored.
//     - The earliest next grant is the cycle after the complete (no back-to-back without a complete).
//   RUN, completion: job_complete[i] sets a sticky done bit, accepted in START or RUN.
//     When all done bits are set and fetch_busy=0, go CPL_ACK.
//   CPL_ACK: job_complete_ack = all ones for exactly 1 cycle.
//     host_job_done pulses in the same cycle; clear sticky bits; next state IDLE.
//   Simultaneous fetch_complete and new request from the same quad: complete is taken first,
//     that quad is lowest priority next cycle.
//   Requests arriving in IDLE/START are held (level) and served in RUN.
//   Async reset mid-job drops every output to its reset value immediately. No pending grant or ack
//     survives reset.
// CONFIGURATION
//   `JOB_TIMEOUT_EN defined:
//     - A 32-bit counter runs in START/RUN and clears on any accept, grant, or complete event.
//     - At TIMEOUT_CYC the block sets timeout_err (sticky until reset), drops all job_start/ack
//       outputs, pulses host_job_done, and returns to IDLE.
//   Undefined: no counter; timeout_err tied 0; the FSM waits indefinitely.
// STRUCTURE
//   cnn_layer_accel_pkg: dispatcher state enum (IDLE, START, RUN, CPL_ACK), JOB_W, QUAD_ID_W.
//   Sub-module cnn_layer_accel_rr_arbiter: NUM_QUADS-wide round-robin grant with
//   enable/pointer-advance. The FSM, sticky vectors and watchdog stay in this module.
// TESTING
//   1. NUM_QUADS=4; job 0xA5..; all quads accept the cycle after start.
//      -> each job_start high 1 cycle, RUN entered, job_parameters==0xA5.. through CPL_ACK.
//   2. Staggered accepts (quad 2 accepts 5 cycles late).
//      -> job_start[2] held until its accept, others drop after their own; RUN only after quad 2.
//   3. Quads 0,1,3 request fetch simultaneously.
//      -> acks in order 0,1,3, each a single pulse, each only after the prior quad's fetch_complete.
//   4. All quads complete while quad 1's fetch is outstanding.
//      -> no CPL_ACK until its fetch_complete; then job_complete_ack=4'hF and host_job_done pulse,
//         both for 1 cycle.
//   5. rst asserted during RUN with a fetch outstanding.
//      -> all outputs 0 the same cycle, host_job_ready=1 after release, next job runs normally.
//   6. `JOB_TIMEOUT_EN, TIMEOUT_CYC=64, quad 3 never completes.
//      -> at cycle 64 of inactivity timeout_err=1, host_job_done pulse, FSM in IDLE.

Source files
------------

// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator job dispatch path.
package cnn_layer_accel_pkg;

  localparam int unsigned JOB_W     = 128;
  localparam int unsigned QUAD_ID_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_CPL_ACK
  } disp_state_t;

  function automatic int unsigned quad_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past each taken grant.
module cnn_layer_accel_rr_arbiter
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            valid
);

  logic [ID_W-1:0] ptr_q;
  int unsigned     idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    valid    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (en && valid) begin
      ptr_q <= (32'(grant_id) == N - 1) ? '0 : ID_W'(32'(grant_id) + 1);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_dispatcher.sv
// Job dispatcher: broadcasts layer jobs to all quads, arbitrates fetches, acks completion.
// Optional watchdog enabled with `JOB_TIMEOUT_EN.
module cnn_layer_accel_job_dispatcher
#(
  parameter int unsigned NUM_QUADS   = 4,
  parameter int unsigned JOB_W       = cnn_layer_accel_pkg::JOB_W,
  parameter int unsigned TIMEOUT_CYC = 2**20,
  localparam int unsigned QID_W      = cnn_layer_accel_pkg::quad_id_w(NUM_QUADS)
) (
  input  logic                 clk_core,
  input  logic                 rst,
  input  logic                 host_job_valid,
  output logic                 host_job_ready,
  input  logic [JOB_W-1:0]     host_job_data,
  output logic                 host_job_done,
  output logic                 busy,
  output logic [NUM_QUADS-1:0] job_start,
  input  logic [NUM_QUADS-1:0] job_accept,
  output logic [JOB_W-1:0]     job_parameters,
  input  logic [NUM_QUADS-1:0] job_fetch_request,
  output logic [NUM_QUADS-1:0] job_fetch_ack,
  input  logic [NUM_QUADS-1:0] job_fetch_complete,
  input  logic [NUM_QUADS-1:0] job_complete,
  output logic [NUM_QUADS-1:0] job_complete_ack,
  output logic [QID_W-1:0]     fetch_grant_id,
  output logic                 fetch_busy,
  output logic                 timeout_err
);

  import cnn_layer_accel_pkg::*;

  disp_state_t          state_q, state_d;
  logic [NUM_QUADS-1:0] acc_q, done_q, ack_q;
  logic                 fbusy_q;
  logic [QID_W-1:0]     gid_q;
  logic [JOB_W-1:0]     param_q;
  logic [NUM_QUADS-1:0] arb_grant;
  logic [QID_W-1:0]     arb_id;
  logic                 arb_valid;
  logic                 fc_hit, grant_en, tmo_fire;

  // A complete from the owner frees the port in the same cycle, so the next
  // grant lands on the following edge; the arbiter pointer has already moved past it.
  assign fc_hit   = fbusy_q && job_fetch_complete[gid_q];
  assign grant_en = (state_q == ST_RUN) && !(&done_q) && (!fbusy_q || fc_hit);

  cnn_layer_accel_rr_arbiter #(
    .N    (NUM_QUADS),
    .ID_W (QID_W)
  ) u_arb (
    .clk      (clk_core),
    .rst_n    (rst),
    .req      (job_fetch_request),
    .en       (grant_en),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .valid    (arb_valid)
  );

  always_comb begin
    state_d          = state_q;
    host_job_ready   = 1'b0;
    host_job_done    = 1'b0;
    job_start        = '0;
    job_complete_ack = '0;
    case (state_q)
      ST_IDLE: begin
        host_job_ready = 1'b1;
        if (host_job_valid) state_d = ST_START;
      end
      ST_START: begin
        job_start = ~acc_q;
        if (&(acc_q | job_accept)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (&done_q && !fbusy_q) state_d = ST_CPL_ACK;
      end
      ST_CPL_ACK: begin
        job_complete_ack = '1;
        host_job_done    = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_fire) begin
      state_d       = ST_IDLE;
      job_start     = '0;
      host_job_done = 1'b1;
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      done_q  <= '0;
      ack_q   <= '0;
      fbusy_q <= 1'b0;
      gid_q   <= '0;
      param_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (state_q == ST_IDLE && host_job_valid) param_q <= host_job_data;
      if (state_q == ST_START) acc_q <= acc_q | job_accept;
      if (state_q == ST_START || state_q == ST_RUN) done_q <= done_q | job_complete;
      if (fc_hit) fbusy_q <= 1'b0;
      if (grant_en && arb_valid) begin
        ack_q   <= arb_grant;
        fbusy_q <= 1'b1;
        gid_q   <= arb_id;
      end
      if (state_q == ST_CPL_ACK || tmo_fire) begin
        acc_q   <= '0;
        done_q  <= '0;
        ack_q   <= '0;
        fbusy_q <= 1'b0;
      end
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign job_parameters = param_q;
  assign job_fetch_ack  = ack_q;
  assign fetch_busy     = fbusy_q;
  assign fetch_grant_id = gid_q;

`ifdef JOB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_err_q;
  logic        tmo_active, tmo_event;

  assign tmo_active = (state_q == ST_START) || (state_q == ST_RUN);
  assign tmo_event  = ((state_q == ST_START) && |(~acc_q & job_accept))
                   || (grant_en && arb_valid) || |job_complete || fc_hit;
  assign tmo_fire   = tmo_active && !tmo_event && (tmo_cnt_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (!tmo_active || tmo_event) tmo_cnt_q <= '0;
      else                          tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (tmo_fire) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
